// File: rtl/param_mux_rr.sv
// N-to-1 channel multiplexer with a registered output stage.
// Selection is either by explicit select (MODE=0) or by round-robin arbitration (MODE=1).
module param_mux_rr #(
    parameter int unsigned W  = 8,
    parameter int unsigned N  = 10,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           MODE,
    input  logic [SW-1:0]  S,
    input  logic [N*W-1:0] I,
    input  logic [N-1:0]   IV,
    output logic [N-1:0]   IR,
    output logic [W-1:0]   Z,
    output logic           ZV,
    input  logic           ZR,
    output logic [15:0]    ACNT
);

    logic [W-1:0]  z_q, z_d;
    logic          zv_q, zv_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [15:0]   acnt_q, acnt_d;

    logic          free;
    logic          acc;
    logic          gnt_any;
    logic [N-1:0]  gnt_oh;
    logic [SW-1:0] gnt_idx;
    logic [SW:0]   rr_sum;
    logic [SW-1:0] rr_idx;
    logic [W-1:0]  z_sel;

    // Grant is purely combinational so MODE/S changes take effect in the same cycle.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        rr_sum  = '0;
        rr_idx  = '0;
        if (!MODE) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (S == SW'(k) && IV[k]) begin
                    gnt_oh[k] = 1'b1;
                    gnt_idx   = SW'(k);
                    gnt_any   = 1'b1;
                end
            end
        end else begin
            for (int unsigned j = 0; j < N; j++) begin
                rr_sum = {1'b0, ptr_q} + (SW+1)'(j);
                if (rr_sum >= (SW+1)'(N)) begin
                    rr_sum = rr_sum - (SW+1)'(N);
                end
                rr_idx = rr_sum[SW-1:0];
                if (!gnt_any && IV[rr_idx]) begin
                    gnt_oh[rr_idx] = 1'b1;
                    gnt_idx        = rr_idx;
                    gnt_any        = 1'b1;
                end
            end
        end
    end

    always_comb begin
        z_sel = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (gnt_oh[k]) begin
                z_sel = I[k*W +: W];
            end
        end
    end

    assign free = RST_N && (!zv_q || ZR);
    assign acc  = free && gnt_any;
    assign IR   = free ? gnt_oh : '0;

    always_comb begin
        z_d    = z_q;
        zv_d   = zv_q;
        ptr_d  = ptr_q;
        acnt_d = acnt_q;
        if (free) begin
            zv_d = acc;
        end
        if (acc) begin
            z_d    = z_sel;
            acnt_d = acnt_q + 16'd1;
            if (MODE) begin
                ptr_d = (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            z_q    <= '0;
            zv_q   <= 1'b0;
            ptr_q  <= '0;
            acnt_q <= '0;
        end else begin
            z_q    <= z_d;
            zv_q   <= zv_d;
            ptr_q  <= ptr_d;
            acnt_q <= acnt_d;
        end
    end

    assign Z    = z_q;
    assign ZV   = zv_q;
    assign ACNT = acnt_q;

endmodule

// File: tb/tb_param_mux_rr.sv
// Directed bench for param_mux_rr (W=8, N=10): reset, select, out-of-range, round-robin,
// stall and reset-during-stall.
module tb_param_mux_rr;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        MODE;
    logic [3:0]  S;
    logic [79:0] I;
    logic [9:0]  IV;
    logic [9:0]  IR;
    logic [7:0]  Z;
    logic        ZV;
    logic        ZR;
    logic [15:0] ACNT;

    int checks = 0;
    int errors = 0;
    logic [9:0] oh;
    int unsigned ex;

    param_mux_rr #(.W(8), .N(10)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .MODE (MODE),
        .S    (S),
        .I    (I),
        .IV   (IV),
        .IR   (IR),
        .Z    (Z),
        .ZV   (ZV),
        .ZR   (ZR),
        .ACNT (ACNT)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N = 1'b0;
        MODE  = 1'b0;
        S     = 4'd0;
        IV    = '1;
        ZR    = 1'b1;
        for (int k = 0; k < 10; k++) I[k*8 +: 8] = 8'(k);
        #1;
        check_eq("rst_ir_pre", 32'(IR), 32'd0);
        step();
        check_eq("rst_z", 32'(Z), 32'd0);
        check_eq("rst_zv", 32'(ZV), 32'd0);
        check_eq("rst_acnt", 32'(ACNT), 32'd0);
        check_eq("rst_ir_post", 32'(IR), 32'd0);

        // Select mode, channel 3.
        RST_N = 1'b1;
        S = 4'd3;
        IV = 10'b0000001000;
        I[3*8 +: 8] = 8'hA5;
        #1;
        check_eq("sel_ir", 32'(IR), 32'h008);
        step();
        check_eq("sel_z", 32'(Z), 32'hA5);
        check_eq("sel_zv", 32'(ZV), 32'd1);
        check_eq("sel_acnt", 32'(ACNT), 32'd1);

        // Out-of-range select.
        S = 4'd12;
        IV = '1;
        #1;
        check_eq("oor_ir", 32'(IR), 32'd0);
        step();
        check_eq("oor_zv", 32'(ZV), 32'd0);
        check_eq("oor_z_hold", 32'(Z), 32'hA5);
        check_eq("oor_acnt", 32'(ACNT), 32'd1);

        // Round-robin from PTR=0 (mode-0 accept must not have moved it).
        I[3*8 +: 8] = 8'd3;
        MODE = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ex = 32'(i % 10);
            oh = 10'd1 << ex;
            #1;
            check_eq($sformatf("rr_ir%0d", i), 32'(IR), 32'(oh));
            step();
            check_eq($sformatf("rr_z%0d", i), 32'(Z), ex);
            check_eq($sformatf("rr_zv%0d", i), 32'(ZV), 32'd1);
        end
        check_eq("rr_acnt", 32'(ACNT), 32'd13);

        // Load channel 7 then stall three cycles.
        IV = 10'b0010000000;
        step();
        check_eq("st_load_z", 32'(Z), 32'h07);
        ZR = 1'b0;
        IV = '1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("st_ir%0d", i), 32'(IR), 32'd0);
            step();
            check_eq($sformatf("st_z%0d", i), 32'(Z), 32'h07);
            check_eq($sformatf("st_zv%0d", i), 32'(ZV), 32'd1);
        end
        check_eq("st_acnt", 32'(ACNT), 32'd14);
        ZR = 1'b1;
        #1;
        check_eq("st_rel_ir", 32'(IR), 32'h100);
        step();
        check_eq("st_rel_z", 32'(Z), 32'h08);
        check_eq("st_rel_zv", 32'(ZV), 32'd1);
        check_eq("st_rel_acnt", 32'(ACNT), 32'd15);

        // Accept channel 4 (PTR -> 5), stall, then reset.
        IV = 10'b0000010000;
        step();
        check_eq("rs_load_z", 32'(Z), 32'h04);
        ZR = 1'b0;
        IV = '1;
        step();
        check_eq("rs_stall_zv", 32'(ZV), 32'd1);
        RST_N = 1'b0;
        #1;
        check_eq("rs_ir", 32'(IR), 32'd0);
        step();
        check_eq("rs_zv", 32'(ZV), 32'd0);
        check_eq("rs_z", 32'(Z), 32'd0);
        check_eq("rs_acnt", 32'(ACNT), 32'd0);
        RST_N = 1'b1;
        ZR = 1'b1;
        IV = 10'b0010001000;
        #1;
        check_eq("rs_rr_ir", 32'(IR), 32'h008);
        step();
        check_eq("rs_rr_z", 32'(Z), 32'h03);
        check_eq("rs_rr_acnt", 32'(ACNT), 32'd1);
        #1;
        check_eq("rs_rr_ir2", 32'(IR), 32'h080);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_mux_rr.md
PARAM_MUX_RR -- requirements
Module: param_mux_rr

Interface
REQ-001 Parameter W, default 8, data width per channel (W >= 1).
REQ-002 Parameter N, default 10, number of input channels (2 <= N <= 64).
REQ-003 Parameter SW, default $clog2(N) (4 for N=10), select width.
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 RST_N  input  1  reset, synchronous, active-low.
REQ-006 MODE  input  1  0 = select-driven, 1 = round-robin arbitration.
REQ-007 S  input  SW  channel select, used only when MODE=0.
REQ-008 I  input  N*W  flattened channel data, channel k at bits [k*W +: W].
REQ-009 IV  input  N  per-channel valid.
REQ-010 IR  output  N  per-channel ready, combinational, one-hot or zero.
REQ-011 Z  output  W  registered output data.
REQ-012 ZV  output  1  registered output valid.
REQ-013 ZR  input  1  downstream ready.
REQ-014 ACNT  output  16  count of accepted transfers.

Function
REQ-015 Output register SHALL be free when ZV=0 or ZR=1; "free" is combinational.
REQ-016 MODE=0: grant = channel S when S < N and IV[S]=1; otherwise no grant.
REQ-017 MODE=0, S >= N (e.g. 10..15 for N=10): no grant, IR all zero, no transfer; Z/ZV follow REQ-022.
REQ-018 MODE=1: grant = first k with IV[k]=1 scanning PTR, PTR+1, ..., N-1, 0, ..., PTR-1; no grant if IV all zero.
REQ-019 PTR SHALL be an internal SW-bit register, range 0..N-1.
REQ-020 IR[g] SHALL be 1 only for granted channel g and only while output register is free; all other IR bits 0.
REQ-021 Accept occurs when IR[g]=1 and IV[g]=1: next edge Z <= channel g data, ZV <= 1.
REQ-022 No accept while free: ZV <= 0 on next edge; Z holds last value.
REQ-023 ZV=1 and ZR=0 (stall): Z and ZV SHALL hold; IR all zero.
REQ-024 Latency: accepted data appears on Z exactly 1 cycle after acceptance; with ZR held 1, throughput 1 transfer/cycle.
REQ-025 MODE=1 accept of g: PTR <= g+1, wrapping to 0 when g = N-1.
REQ-026 MODE=0 accepts SHALL NOT change PTR.
REQ-027 MODE and S may change any cycle; grant re-evaluated combinationally, no latched decision.
REQ-028 ACNT SHALL increment by 1 per accept, wrapping 16'hFFFF -> 0.
REQ-029 Simultaneous output drain (ZR=1) and new accept in same cycle SHALL replace Z without bubble.

Reset
REQ-030 RST_N=0 at an edge: Z <= 0, ZV <= 0, PTR <= 0, ACNT <= 0.
REQ-031 While RST_N=0, IR SHALL be all zero; no accept occurs.
REQ-032 Reset mid-stall SHALL discard the held output (ZV=0 after the edge); no partial transfer counted.

Verification
REQ-033 Reset: RST_N=0 one cycle with IV=all ones -> Z=0, ZV=0, ACNT=0, IR=0 throughout.
REQ-034 Select mode: MODE=0, S=3, IV[3]=1, I3=8'hA5, ZR=1 -> IR=10'b0000001000; next cycle Z=8'hA5, ZV=1, ACNT=1.
REQ-035 Out-of-range: MODE=0, S=12, IV=all ones -> IR=0; next cycle ZV=0, ACNT unchanged.
REQ-036 Round-robin: MODE=1, IV=all ones, ZR=1 for 12 cycles, I_k=k -> Z sequence 0,1,...,9,0,1; PTR wraps 9 -> 0.
REQ-037 Stall: MODE=1, Z=8'h07 with ZV=1, ZR=0 for 3 cycles -> Z=8'h07, ZV=1 hold, IR=0; ZR=1 -> next accept loads next channel same cycle.
REQ-038 Reset mid-stall: ZV=1, ZR=0, PTR=5, RST_N=0 -> next cycle ZV=0, PTR=0, ACNT=0; first MODE=1 accept after release grants lowest valid channel.
